// File: rtl/hashmap.sv
// Direct-mapped key/value store: one registered write port, one combinational
// read port, single-cycle bulk clear and a combinational collision flag.
module hashmap #(
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 8,
    parameter int CACHE_SIZE  = 16,
    parameter int OVERWRITE   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_WIDTH-1:0]   write_key,
    input  logic [VALUE_WIDTH-1:0] write_value,
    input  logic                   write_request,
    output logic                   collision,
    input  logic [KEY_WIDTH-1:0]   read_key,
    output logic [VALUE_WIDTH-1:0] read_value,
    output logic                   read_response,
    input  logic                   clear_cache
);

    localparam int INDEX_WIDTH = $clog2(CACHE_SIZE);
    localparam int NUM_CHUNKS  = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
    localparam int PAD_WIDTH   = NUM_CHUNKS * INDEX_WIDTH;

    // XOR-fold of the key in INDEX_WIDTH chunks; a key no wider than the
    // index collapses to a single zero-extended chunk.
    function automatic logic [INDEX_WIDTH-1:0] hash(input logic [KEY_WIDTH-1:0] key);
        logic [PAD_WIDTH-1:0]   padded;
        logic [INDEX_WIDTH-1:0] acc;
        padded                 = '0;
        padded[KEY_WIDTH-1:0]  = key;
        acc                    = '0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            acc = acc ^ padded[i*INDEX_WIDTH +: INDEX_WIDTH];
        end
        return acc;
    endfunction

    logic [CACHE_SIZE-1:0]  slot_valid;
    logic [KEY_WIDTH-1:0]   slot_key   [CACHE_SIZE];
    logic [VALUE_WIDTH-1:0] slot_value [CACHE_SIZE];

    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [INDEX_WIDTH-1:0] wr_idx;
    logic                   wr_slot_valid;
    logic                   wr_key_match;
    logic                   wr_enable;

    always_comb begin
        rd_idx        = hash(read_key);
        read_response = slot_valid[rd_idx] && (slot_key[rd_idx] == read_key);
        read_value    = read_response ? slot_value[rd_idx] : '0;
    end

    always_comb begin
        wr_idx        = hash(write_key);
        wr_slot_valid = slot_valid[wr_idx];
        wr_key_match  = slot_key[wr_idx] == write_key;
        collision     = write_request && wr_slot_valid && !wr_key_match;
        // An occupied slot is only touched when overwriting is enabled,
        // which covers both same-key updates and evictions.
        wr_enable     = write_request && (!wr_slot_valid || (OVERWRITE != 0));
    end

    always_ff @(posedge clk) begin
        if (rst || clear_cache) begin
            slot_valid <= '0;
        end else if (wr_enable) begin
            slot_valid[wr_idx] <= 1'b1;
            slot_key[wr_idx]   <= write_key;
            slot_value[wr_idx] <= write_value;
        end
    end

endmodule

// File: tb/tb_hashmap.sv
// Bench for hashmap: two instances (overwrite on/off) checked every cycle
// against a slot-array model, plus directed literal expectations.
module tb_hashmap;

    localparam int KW = 4;
    localparam int VW = 3;
    localparam int CS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [KW-1:0] write_key;
    logic [VW-1:0] write_value;
    logic          write_request;
    logic [KW-1:0] read_key;
    logic          clear_cache;

    logic          col_ow1, rr_ow1, col_ow0, rr_ow0;
    logic [VW-1:0] rv_ow1, rv_ow0;

    int checks   = 0;
    int failures = 0;
    bit ready    = 1'b0;

    // Model state, index 1 = overwrite enabled, index 0 = overwrite disabled
    bit            m_valid [2][CS];
    logic [KW-1:0] m_key   [2][CS];
    logic [VW-1:0] m_value [2][CS];

    hashmap #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CACHE_SIZE(CS), .OVERWRITE(1)) dut_ow1 (
        .clk(clk), .rst(rst), .write_key(write_key), .write_value(write_value),
        .write_request(write_request), .collision(col_ow1), .read_key(read_key),
        .read_value(rv_ow1), .read_response(rr_ow1), .clear_cache(clear_cache)
    );

    hashmap #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CACHE_SIZE(CS), .OVERWRITE(0)) dut_ow0 (
        .clk(clk), .rst(rst), .write_key(write_key), .write_value(write_value),
        .write_request(write_request), .collision(col_ow0), .read_key(read_key),
        .read_value(rv_ow0), .read_response(rr_ow0), .clear_cache(clear_cache)
    );

    always #5 clk = ~clk;

    function automatic int h(input int k);
        return (k % 4) ^ ((k / 4) % 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model commit on each rising edge
    always @(posedge clk) begin
        for (int o = 0; o < 2; o++) begin
            if (rst || clear_cache) begin
                for (int s = 0; s < CS; s++) m_valid[o][s] = 1'b0;
            end else if (write_request) begin
                int wi;
                wi = h(int'(write_key));
                if (!m_valid[o][wi] || o == 1) begin
                    m_valid[o][wi] = 1'b1;
                    m_key[o][wi]   = write_key;
                    m_value[o][wi] = write_value;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (ready) begin
            for (int o = 0; o < 2; o++) begin
                int       ri, wi;
                bit       hit, ecol;
                logic [VW-1:0] ev;
                ri   = h(int'(read_key));
                wi   = h(int'(write_key));
                hit  = m_valid[o][ri] && (m_key[o][ri] == read_key);
                ev   = hit ? m_value[o][ri] : '0;
                ecol = write_request && m_valid[o][wi] && (m_key[o][wi] != write_key);
                if (o == 1) begin
                    check("model_rr_ow1", 32'(rr_ow1), 32'(hit));
                    check("model_rv_ow1", 32'(rv_ow1), 32'(ev));
                    check("model_col_ow1", 32'(col_ow1), 32'(ecol));
                end else begin
                    check("model_rr_ow0", 32'(rr_ow0), 32'(hit));
                    check("model_rv_ow0", 32'(rv_ow0), 32'(ev));
                    check("model_col_ow0", 32'(col_ow0), 32'(ecol));
                end
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic wreq,
                        input logic [KW-1:0] wk, input logic [VW-1:0] wv,
                        input logic [KW-1:0] rk);
        @(posedge clk);
        #1;
        rst           = r;
        clear_cache   = c;
        write_request = wreq;
        write_key     = wk;
        write_value   = wv;
        read_key      = rk;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clear_cache = 1'b0; write_request = 1'b0;
        write_key = '0; write_value = '0; read_key = 4'h3;
        @(posedge clk);
        #1 ready = 1'b1;

        // Reset then read miss
        step(1, 0, 0, 4'h0, 3'd0, 4'h3);
        step(0, 0, 0, 4'h0, 3'd0, 4'h3);
        check("reset_rr", 32'(rr_ow1), 32'd0);
        check("reset_rv", 32'(rv_ow1), 32'd0);

        // Write 3->5, same-cycle read misses, next-cycle read hits
        step(0, 0, 1, 4'h3, 3'd5, 4'h3);
        check("same_cycle_rr", 32'(rr_ow1), 32'd0);
        step(0, 0, 0, 4'h0, 3'd0, 4'h3);
        check("hit_rr", 32'(rr_ow1), 32'd1);
        check("hit_rv", 32'(rv_ow1), 32'd5);
        check("hit_rv_ow0", 32'(rv_ow0), 32'd5);

        // Different-key collision in slot 0
        step(0, 0, 1, 4'h5, 3'd2, 4'h0);
        step(0, 0, 1, 4'hA, 3'd6, 4'h0);
        check("collide_ow1", 32'(col_ow1), 32'd1);
        check("collide_ow0", 32'(col_ow0), 32'd1);
        step(0, 0, 0, 4'h0, 3'd0, 4'hA);
        check("evict_new_rr_ow1", 32'(rr_ow1), 32'd1);
        check("evict_new_rv_ow1", 32'(rv_ow1), 32'd6);
        check("evict_new_rr_ow0", 32'(rr_ow0), 32'd0);
        step(0, 0, 0, 4'h0, 3'd0, 4'h5);
        check("evict_old_rr_ow1", 32'(rr_ow1), 32'd0);
        check("keep_old_rr_ow0", 32'(rr_ow0), 32'd1);
        check("keep_old_rv_ow0", 32'(rv_ow0), 32'd2);

        // Same-key update never collides
        step(0, 0, 1, 4'h7, 3'd1, 4'h0);
        step(0, 0, 1, 4'h7, 3'd4, 4'h0);
        check("samekey_col_ow1", 32'(col_ow1), 32'd0);
        check("samekey_col_ow0", 32'(col_ow0), 32'd0);
        step(0, 0, 0, 4'h0, 3'd0, 4'h7);
        check("update_rv_ow1", 32'(rv_ow1), 32'd4);
        check("update_rv_ow0", 32'(rv_ow0), 32'd1);

        // Fill, then clear (and later reset) alongside a write
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 0, 0, 4'h0, 3'd0, 4'h0);
            for (int k = 0; k < 4; k++) step(0, 0, 1, 4'(k), 3'(k + 1), 4'(k));
            step(0, 0, 0, 4'h0, 3'd0, 4'h2);
            check("filled_rv", 32'(rv_ow1), 32'd3);
            if (pass == 0) step(0, 1, 1, 4'h1, 3'd7, 4'h1);
            else           step(1, 0, 1, 4'h1, 3'd7, 4'h1);
            for (int k = 0; k < 4; k++) begin
                step(0, 0, 0, 4'h0, 3'd0, 4'(k));
                check(pass == 0 ? "clear_rr_ow1" : "rst_rr_ow1", 32'(rr_ow1), 32'd0);
                check(pass == 0 ? "clear_rr_ow0" : "rst_rr_ow0", 32'(rr_ow0), 32'd0);
            end
        end

        // Two-sum stream, target 6, elements [3,3]
        step(1, 0, 0, 4'h0, 3'd0, 4'h0);
        step(0, 0, 1, 4'h3, 3'd0, 4'h3);
        check("twosum_c0_rr", 32'(rr_ow1), 32'd0);
        step(0, 0, 1, 4'h3, 3'd1, 4'h3);
        check("twosum_c1_rr", 32'(rr_ow1), 32'd1);
        check("twosum_c1_rv", 32'(rv_ow1), 32'd0);
        check("twosum_c1_col", 32'(col_ow1), 32'd0);

        step(0, 0, 0, 4'h0, 3'd0, 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
